ebpc_enc_arbiter: RTL

Stream-granular round-robin arbiter that shares one `ebpc_encoder` instance between `N_REQ` independent activation streams. It grants one requester at a time for a whole stream (first beat through the beat carrying `last`) and forwards that stream to the encoder input. After the last beat it holds off the next grant until the encoder has flushed and reports idle, so the encoder's ZNZ and BPC outputs never interleave two streams. On completion it emits a per-stream done record (requester ID, beat count) for the downstream packer and DMA.

---
 rtl/ebpc_pkg.sv | 34 +++
 rtl/ebpc_rr_pick.sv | 20 ++
 rtl/ebpc_enc_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/ebpc_pkg.sv
// Shared types and helpers for the EBPC encoder datapath and its stream arbiters.
package ebpc_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned MAX_REQ = 32;
  localparam int unsigned PTR_W   = $clog2(MAX_REQ);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } arb_state_t;

  // First set bit of vld[0..n-1] searching upward from ptr with wrap; ptr when none set.
  function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] vld,
                                          input int unsigned        ptr,
                                          input int unsigned        n);
    int unsigned cand;
    int unsigned res;
    logic        found;
    res   = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      cand = ptr + k;
      if (cand >= n) cand = cand - n;
      if (k < n && !found && vld[cand[PTR_W-1:0]]) begin
        res   = cand;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ebpc_rr_pick.sv
// Combinational N-way rotating priority encoder.
module ebpc_rr_pick
  import ebpc_pkg::*;
#(
  parameter  int unsigned N     = 4,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vld,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [MAX_REQ-1:0] vld_ext;

  assign vld_ext = MAX_REQ'(vld);
  assign idx     = IDX_W'(rr_pick(vld_ext, 32'(ptr), N));
  assign any     = |vld;

endmodule

// File: rtl/ebpc_enc_arbiter.sv
// Stream-granular round-robin arbiter sharing one ebpc_encoder between N_REQ streams.
module ebpc_enc_arbiter
  import ebpc_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  parameter  int unsigned CNT_W = 24,
  localparam int unsigned IDX_W = $clog2(N_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [N_REQ-1:0][DATA_W-1:0]  req_data_i,
  input  logic [N_REQ-1:0]              req_last_i,
  input  logic [N_REQ-1:0]              req_vld_i,
  output logic [N_REQ-1:0]              req_rdy_o,
  output logic [DATA_W-1:0]             enc_data_o,
  output logic                          enc_last_o,
  output logic                          enc_vld_o,
  input  logic                          enc_rdy_i,
  input  logic                          enc_idle_i,
  output logic [IDX_W-1:0]              grant_o,
  output logic                          grant_vld_o,
  output logic                          done_o,
  output logic [IDX_W-1:0]              done_id_o,
  output logic [CNT_W-1:0]              done_beats_o
);

  arb_state_t       state_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] grant_q;
  logic [IDX_W-1:0] done_id_q;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] rr_next;
  logic [CNT_W-1:0] beats_q;
  logic [CNT_W-1:0] done_beats_q;
  logic             drain_guard_q;
  logic             pick_any;
  logic             hs;

  ebpc_rr_pick #(.N(N_REQ)) u_rr_pick (
    .vld (req_vld_i),
    .ptr (rr_ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    req_rdy_o  = '0;
    enc_data_o = '0;
    enc_last_o = 1'b0;
    enc_vld_o  = 1'b0;
    if (state_q == STREAM) begin
      enc_data_o         = req_data_i[grant_q];
      enc_last_o         = req_last_i[grant_q];
      enc_vld_o          = req_vld_i[grant_q];
      req_rdy_o[grant_q] = enc_rdy_i;
    end
  end

  assign hs          = enc_vld_o && enc_rdy_i;
  assign grant_o     = grant_q;
  assign grant_vld_o = (state_q != IDLE);
  assign done_o      = (state_q == DRAIN) && !drain_guard_q && enc_idle_i;
  // Record fields are live during the pulse and held afterwards.
  assign done_id_o    = done_o ? grant_q : done_id_q;
  assign done_beats_o = done_o ? beats_q : done_beats_q;
  assign rr_next      = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + IDX_W'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      beats_q       <= '0;
      drain_guard_q <= 1'b0;
      done_id_q     <= '0;
      done_beats_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enc_idle_i && pick_any) begin
            grant_q <= pick_idx;
            beats_q <= '0;
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (hs) begin
            if (beats_q != '1) beats_q <= beats_q + CNT_W'(1);
            if (enc_last_o) begin
              state_q       <= DRAIN;
              drain_guard_q <= 1'b1;
            end
          end
        end
        DRAIN: begin
          // Encoder may still report idle right after taking the last beat.
          if (drain_guard_q) begin
            drain_guard_q <= 1'b0;
          end else if (enc_idle_i) begin
            rr_ptr_q     <= rr_next;
            done_id_q    <= grant_q;
            done_beats_q <= beats_q;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
